// File: rtl/telemetry_pkg.sv
// Shared constants and types for the telemetry serial link (frame format, FSM encodings).
// The transmitter side imports the same delimiters, frame length and default baud divider.
package telemetry_pkg;

    localparam int DEFAULT_BAUD_DIV = 5208;
    localparam int DEFAULT_BYTE_TO  = 104167;
    localparam int FRAME_LEN        = 8;
    localparam logic [7:0] DELIM1   = 8'hAA;
    localparam logic [7:0] DELIM2   = 8'h55;

    typedef enum logic [2:0] {
        SYNC1, SYNC2, P1, P2, P3, P4, P5, P6
    } frame_state_t;

    typedef enum logic [2:0] {
        RX_WAIT_HIGH, RX_IDLE, RX_START, RX_DATA, RX_STOP
    } uart_state_t;

    typedef struct packed {
        frame_state_t frame;
        uart_state_t  uart;
    } rx_dbg_t;

    // Which 12-bit word a payload state belongs to: 0 batt_v, 1 avg_curr, 2 avg_torque.
    function automatic logic [1:0] word_index(input frame_state_t s);
        case (s)
            P1, P2:  return 2'd0;
            P3, P4:  return 2'd1;
            default: return 2'd2;
        endcase
    endfunction

endpackage

// File: rtl/telem_uart_rx.sv
// 8N1 byte receiver: 2-flop synchronizer, mid-bit sampling, glitch-filtered start,
// one-cycle rdy on a good byte and byte_err on a low stop bit.
module telem_uart_rx
    import telemetry_pkg::*;
#(
    parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    output logic [7:0]  rx_data,
    output logic        rdy,
    output logic        byte_err,
    output uart_state_t dbg_state
);

    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] ARM_LAST  = CW'(2);

    uart_state_t   state, state_n;
    logic [1:0]    sync_q;
    logic          rx_s;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          baud_done;

    assign rx_s      = sync_q[1];
    assign dbg_state = state;
    assign baud_done = (baud_cnt == ((state == RX_START) ? HALF_LAST : FULL_LAST));

    always_ff @(posedge clk) begin
        if (rst) state <= RX_WAIT_HIGH;
        else     state <= state_n;
    end

    // The synchronizer is preset high, so arming needs three high samples in a row
    // to be sure the real line (not the preset) is idle.
    always_comb begin
        state_n = state;
        case (state)
            RX_WAIT_HIGH: if (rx_s && baud_cnt == ARM_LAST) state_n = RX_IDLE;
            RX_IDLE:      if (!rx_s) state_n = RX_START;
            RX_START:     if (baud_done) state_n = rx_s ? RX_IDLE : RX_DATA;
            RX_DATA:      if (baud_done && bit_cnt == 3'd7) state_n = RX_STOP;
            RX_STOP:      if (baud_done) state_n = rx_s ? RX_IDLE : RX_WAIT_HIGH;
            default:      state_n = RX_WAIT_HIGH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q   <= 2'b11;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            rx_data  <= '0;
            rdy      <= 1'b0;
            byte_err <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], rx};
            rdy      <= 1'b0;
            byte_err <= 1'b0;
            case (state)
                RX_WAIT_HIGH: baud_cnt <= rx_s ? baud_cnt + CW'(1) : '0;
                RX_IDLE: begin
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                end
                default: baud_cnt <= baud_done ? '0 : baud_cnt + CW'(1);
            endcase
            if (state == RX_DATA && baud_done) begin
                shreg   <= {rx_s, shreg[7:1]};
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (state == RX_STOP && baud_done) begin
                if (rx_s) begin
                    rdy     <= 1'b1;
                    rx_data <= shreg;
                end else begin
                    byte_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/telemetry_rx.sv
// Telemetry frame receiver: reassembles AA 55 + six payload bytes into three 12-bit words,
// updating outputs only on a complete good frame and pulsing pkt_err on discarded frames.
module telemetry_rx
    import telemetry_pkg::*;
#(
    parameter int BAUD_DIV = DEFAULT_BAUD_DIV,
    parameter int BYTE_TO  = DEFAULT_BYTE_TO
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RX,
    output logic [11:0] batt_v,
    output logic [11:0] avg_curr,
    output logic [11:0] avg_torque,
    output logic        pkt_vld,
    output logic        pkt_err,
    output rx_dbg_t     dbg
);

    localparam int NUM_WORDS = (FRAME_LEN - 2) / 2;
    localparam int GW = $clog2(BYTE_TO + 1);
    localparam logic [GW-1:0] GAP_LIMIT = GW'(BYTE_TO);

    frame_state_t  state, state_n;
    logic [7:0]    rx_byte;
    logic          rdy, byte_err, timeout;
    logic [GW-1:0] gap_cnt;
    logic [3:0]    hi_q [NUM_WORDS];
    logic [7:0]    lo_q [NUM_WORDS-1];
    logic [1:0]    widx;
    logic          ld_hi, ld_lo, commit, err_n;
    uart_state_t   uart_state;

    telem_uart_rx #(.BAUD_DIV(BAUD_DIV)) u_uart (
        .clk       (clk),
        .rst       (rst),
        .rx        (RX),
        .rx_data   (rx_byte),
        .rdy       (rdy),
        .byte_err  (byte_err),
        .dbg_state (uart_state)
    );

    assign dbg     = '{frame: state, uart: uart_state};
    assign widx    = word_index(state);
    assign timeout = (state != SYNC1) && (gap_cnt == GAP_LIMIT);

    always_ff @(posedge clk) begin
        if (rst) state <= SYNC1;
        else     state <= state_n;
    end

    // A received byte takes priority over a coincident timeout.
    always_comb begin
        state_n = state;
        ld_hi   = 1'b0;
        ld_lo   = 1'b0;
        commit  = 1'b0;
        err_n   = 1'b0;
        if (rdy) begin
            case (state)
                SYNC1: if (rx_byte == DELIM1) state_n = SYNC2;
                SYNC2: begin
                    if (rx_byte == DELIM2)      state_n = P1;
                    else if (rx_byte != DELIM1) state_n = SYNC1;
                end
                P1, P3, P5: begin
                    if (rx_byte[7:4] == 4'h0) begin
                        ld_hi   = 1'b1;
                        state_n = (state == P1) ? P2 : (state == P3) ? P4 : P6;
                    end else begin
                        err_n   = 1'b1;
                        state_n = (rx_byte == DELIM1) ? SYNC2 : SYNC1;
                    end
                end
                P2: begin
                    ld_lo   = 1'b1;
                    state_n = P3;
                end
                P4: begin
                    ld_lo   = 1'b1;
                    state_n = P5;
                end
                default: begin
                    commit  = 1'b1;
                    state_n = SYNC1;
                end
            endcase
        end else if (byte_err || timeout) begin
            err_n   = (state != SYNC1) && (state != SYNC2);
            state_n = SYNC1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gap_cnt    <= '0;
            batt_v     <= '0;
            avg_curr   <= '0;
            avg_torque <= '0;
            pkt_vld    <= 1'b0;
            pkt_err    <= 1'b0;
            for (int i = 0; i < NUM_WORDS; i++) hi_q[i] <= '0;
            for (int i = 0; i < NUM_WORDS - 1; i++) lo_q[i] <= '0;
        end else begin
            pkt_vld <= commit;
            pkt_err <= err_n;
            if (rdy || timeout || state == SYNC1) gap_cnt <= '0;
            else                                  gap_cnt <= gap_cnt + GW'(1);
            if (ld_hi) hi_q[widx]    <= rx_byte[3:0];
            if (ld_lo) lo_q[widx[0]] <= rx_byte;
            // The last low byte goes straight to the output so all three words land together.
            if (commit) begin
                batt_v     <= {hi_q[0], lo_q[0]};
                avg_curr   <= {hi_q[1], lo_q[1]};
                avg_torque <= {hi_q[2], rx_byte};
            end
        end
    end

endmodule

// File: tb/tb_telemetry_rx.sv
// Directed and randomized byte streams driven serially into telemetry_rx, checked against
// a frame-level reference model of the link protocol.
module tb_telemetry_rx;
    import telemetry_pkg::*;

    localparam int BD = 16;
    localparam int TO = 400;
    localparam int LAT = BD / 2 + 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        RX  = 1'b1;
    logic [11:0] batt_v, avg_curr, avg_torque;
    logic        pkt_vld, pkt_err;
    rx_dbg_t     dbg;

    always #5 clk = ~clk;

    telemetry_rx #(.BAUD_DIV(BD), .BYTE_TO(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .RX         (RX),
        .batt_v     (batt_v),
        .avg_curr   (avg_curr),
        .avg_torque (avg_torque),
        .pkt_vld    (pkt_vld),
        .pkt_err    (pkt_err),
        .dbg        (dbg)
    );

    int tests = 0, fails = 0;
    int cyc = 0, vld_cnt = 0, err_cnt = 0, both_cnt = 0;
    int last_vld_cyc = 0, last_err_cyc = 0, stop_cyc = 0;
    logic [35:0] obs_q[$];
    logic [35:0] exp_q[$];

    // reference model state
    int          exp_vld = 0, exp_err = 0;
    logic [11:0] exp_bv = '0, exp_cu = '0, exp_tq = '0;
    bit          seen_aa = 0, in_pl = 0;
    logic [7:0]  pl[$];
    logic [7:0]  seq[$];
    int          bad_idx = -1;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (pkt_vld) begin
            vld_cnt++;
            last_vld_cyc = cyc;
            obs_q.push_back({batt_v, avg_curr, avg_torque});
        end
        if (pkt_err) begin
            err_cnt++;
            last_err_cyc = cyc;
        end
        if (pkt_vld && pkt_err) both_cnt++;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (in_pl) begin
            if (pl.size() % 2 == 0 && b[7:4] != 4'h0) begin
                exp_err++;
                in_pl   = 0;
                seen_aa = (b == 8'hAA);
            end else begin
                pl.push_back(b);
                if (pl.size() == 6) begin
                    exp_bv = {pl[0][3:0], pl[1]};
                    exp_cu = {pl[2][3:0], pl[3]};
                    exp_tq = {pl[4][3:0], pl[5]};
                    exp_vld++;
                    exp_q.push_back({exp_bv, exp_cu, exp_tq});
                    in_pl   = 0;
                    seen_aa = 0;
                end
            end
        end else if (seen_aa) begin
            if (b == 8'h55) begin
                in_pl = 1;
                pl.delete();
            end else if (b != 8'hAA) begin
                seen_aa = 0;
            end
        end else begin
            seen_aa = (b == 8'hAA);
        end
    endtask

    // byte_err and gap timeout abandon the frame the same way
    task automatic model_abort();
        if (in_pl) exp_err++;
        in_pl   = 0;
        seen_aa = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop);
        RX = 1'b0;
        repeat (BD) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            repeat (BD) @(negedge clk);
        end
        stop_cyc = cyc;
        RX = stop;
        repeat (BD) @(negedge clk);
        if (!stop) begin
            RX = 1'b1;
            repeat (BD) @(negedge clk);
        end
    endtask

    task automatic send_seq();
        for (int i = 0; i < seq.size(); i++) begin
            send_byte(seq[i], i != bad_idx);
            if (i != bad_idx) model_byte(seq[i]);
            else              model_abort();
            RX = 1'b1;
            repeat ($urandom_range(0, 6)) @(negedge clk);
        end
        seq.delete();
        bad_idx = -1;
    endtask

    task automatic push_frame(input logic [11:0] a, input logic [11:0] b, input logic [11:0] c);
        seq.push_back(8'hAA);
        seq.push_back(8'h55);
        seq.push_back({4'h0, a[11:8]});
        seq.push_back(a[7:0]);
        seq.push_back({4'h0, b[11:8]});
        seq.push_back(b[7:0]);
        seq.push_back({4'h0, c[11:8]});
        seq.push_back(c[7:0]);
    endtask

    task automatic idle_timeout();
        RX = 1'b1;
        repeat (TO + 40) @(negedge clk);
        model_abort();
    endtask

    task automatic check_step(input string tag);
        repeat (20) @(negedge clk);
        check({tag, "/vld_count"}, 36'(vld_cnt), 36'(exp_vld));
        check({tag, "/err_count"}, 36'(err_cnt), 36'(exp_err));
        check({tag, "/vld_err_overlap"}, 36'(both_cnt), 36'd0);
        check({tag, "/batt_v"}, 36'(batt_v), 36'(exp_bv));
        check({tag, "/avg_curr"}, 36'(avg_curr), 36'(exp_cu));
        check({tag, "/avg_torque"}, 36'(avg_torque), 36'(exp_tq));
        while (exp_q.size() > 0 && obs_q.size() > 0)
            check({tag, "/frame_at_vld"}, obs_q.pop_front(), exp_q.pop_front());
        exp_q.delete();
        obs_q.delete();
    endtask

    initial begin
        int kind, pos;
        logic [11:0] a, b, c;

        // reset state
        rst = 1'b1;
        RX  = 1'b1;
        repeat (4) @(negedge clk);
        check("rst/batt_v", 36'(batt_v), 36'd0);
        check("rst/avg_curr", 36'(avg_curr), 36'd0);
        check("rst/avg_torque", 36'(avg_torque), 36'd0);
        check("rst/pkt_vld", 36'(pkt_vld), 36'd0);
        check("rst/pkt_err", 36'(pkt_err), 36'd0);
        check("rst/frame_state", 36'(dbg.frame), 36'(SYNC1));
        check("rst/uart_state", 36'(dbg.uart), 36'(RX_WAIT_HIGH));
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // clean frame
        push_frame(12'hABC, 12'h123, 12'h7FF);
        send_seq();
        check_step("clean");
        check("clean/batt_v_const", 36'(batt_v), 36'hABC);
        check("clean/avg_curr_const", 36'(avg_curr), 36'h123);
        check("clean/avg_torque_const", 36'(avg_torque), 36'h7FF);
        check("clean/vld_latency", 36'(last_vld_cyc - stop_cyc), 36'(LAT));

        // garbage then resync, with a repeated 0xAA
        seq = '{8'h13, 8'hAA};
        push_frame(12'hFFF, 12'h000, 12'h800);
        send_seq();
        check_step("resync");
        check("resync/avg_torque_const", 36'(avg_torque), 36'h800);

        // bad high nibble, then a clean frame
        seq = '{8'hAA, 8'h55, 8'h1F};
        send_seq();
        check_step("bad_nibble");
        check("bad_nibble/err_latency", 36'(last_err_cyc - stop_cyc), 36'(LAT));
        push_frame(12'h321, 12'h654, 12'h987);
        send_seq();
        check_step("after_bad_nibble");

        // mid-frame gap beyond the byte timeout
        seq = '{8'hAA, 8'h55, 8'h0A};
        send_seq();
        idle_timeout();
        check_step("gap");
        check("gap/frame_state", 36'(dbg.frame), 36'(SYNC1));
        push_frame(12'h0F0, 12'hF0F, 12'h5A5);
        send_seq();
        check_step("after_gap");

        // stop bit forced low on the fourth payload byte
        push_frame(12'h102, 12'h304, 12'h506);
        bad_idx = 5;
        send_seq();
        idle_timeout();
        check_step("framing");

        // randomized streams
        for (int it = 0; it < 16; it++) begin
            kind = $urandom_range(0, 3);
            a = 12'($urandom_range(0, 4095));
            b = 12'($urandom_range(0, 4095));
            c = 12'($urandom_range(0, 4095));
            if (kind == 1)
                repeat ($urandom_range(1, 3)) seq.push_back(8'($urandom_range(0, 255)));
            push_frame(a, b, c);
            if (kind == 2) begin
                pos = $urandom_range(2, 7);
                seq[pos] = 8'($urandom_range(0, 255));
            end
            if (kind == 3) bad_idx = $urandom_range(0, 7);
            send_seq();
            idle_timeout();
            check_step("random");
        end

        // reset asserted mid-frame and mid-byte, line held low across it
        push_frame(12'h9AB, 12'hCDE, 12'h0F1);
        send_seq();
        seq = '{8'hAA, 8'h55, 8'h0A, 8'hBC};
        send_seq();
        RX = 1'b0;
        repeat (3 * BD) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst/batt_v", 36'(batt_v), 36'd0);
        check("midrst/avg_curr", 36'(avg_curr), 36'd0);
        check("midrst/avg_torque", 36'(avg_torque), 36'd0);
        @(negedge clk);
        rst = 1'b0;
        in_pl   = 0;
        seen_aa = 0;
        exp_bv  = '0;
        exp_cu  = '0;
        exp_tq  = '0;
        repeat (3 * BD) @(negedge clk);
        check("midrst/uart_rearm", 36'(dbg.uart), 36'(RX_WAIT_HIGH));
        check("midrst/frame_state", 36'(dbg.frame), 36'(SYNC1));
        RX = 1'b1;
        repeat (BD) @(negedge clk);
        push_frame(12'h456, 12'h789, 12'hABC);
        send_seq();
        check_step("after_midrst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
